// File: rtl/karatsuba_seq32_ctrl_pkg.sv
// Shared constants for the sequential Karatsuba multiplier: FSM state encodings and default width.
// Imported by karatsuba_seq32_ctrl and kseq_mid_fix.
package karatsuba_seq32_ctrl_pkg;

  localparam int KS_N_DEFAULT = 32;

  localparam logic [2:0] KS_IDLE = 3'd0;
  localparam logic [2:0] KS_Z0   = 3'd1;
  localparam logic [2:0] KS_Z2   = 3'd2;
  localparam logic [2:0] KS_Z1   = 3'd3;
  localparam logic [2:0] KS_DONE = 3'd4;

  // Sum of the two halves of an operand, one bit wider than a half.
  function automatic logic [KS_N_DEFAULT/2:0] half_sum_default(input logic [KS_N_DEFAULT-1:0] v);
    return {1'b0, v[KS_N_DEFAULT/2-1:0]} + {1'b0, v[KS_N_DEFAULT-1:KS_N_DEFAULT/2]};
  endfunction

endpackage

// File: rtl/karatsuba_16.sv
// Shared combinational W x W unsigned multiplier core used once per cycle by the sequencer.
module karatsuba_16 #(
  parameter int W = 16
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] prod
);

  assign prod = x * y;

endmodule

// File: rtl/kseq_mid_fix.sv
// Middle Karatsuba term: widens core(la,lb) back to (a_lo+a_hi)*(b_lo+b_hi) using the
// half-sum carries, then removes z0 and z2. Purely combinational.
module kseq_mid_fix
  import karatsuba_seq32_ctrl_pkg::*;
#(
  parameter int N = KS_N_DEFAULT
) (
  input  logic [N/2-1:0] la,
  input  logic [N/2-1:0] lb,
  input  logic           ca,
  input  logic           cb,
  input  logic [N-1:0]   core_p,
  input  logic [N-1:0]   z0,
  input  logic [N-1:0]   z2,
  output logic [N+1:0]   mid
);

  localparam int H = N / 2;
  localparam int W = N + 2;

  logic [W-1:0] m;
  logic [W-1:0] add_la;
  logic [W-1:0] add_lb;
  logic [W-1:0] add_cc;

  always_comb begin
    add_la = cb ? (W'(la) << H) : '0;
    add_lb = ca ? (W'(lb) << H) : '0;
    add_cc = (ca & cb) ? (W'(1) << N) : '0;
    m      = W'(core_p) + add_la + add_lb + add_cc;
    // m >= z0 + z2 always, so the subtraction never wraps.
    mid    = m - W'(z0) - W'(z2);
  end

endmodule

// File: rtl/karatsuba_seq32_ctrl.sv
// Sequential N x N multiplier: three passes through one N/2 core (z0, z2, z1), then recombine.
// Optional KSEQ_ACCEPT_IN_DONE_EN lets a new operand pair be accepted in the same cycle a result leaves.
module karatsuba_seq32_ctrl
  import karatsuba_seq32_ctrl_pkg::*;
#(
  parameter int N = KS_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int H = N / 2;

  logic [2:0]     state_reg;
  logic [2:0]     state_next;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   z0_reg;
  logic [N-1:0]   z2_reg;
  logic [2*N-1:0] p_reg;

  logic           accept;
  logic [H:0]     sa;
  logic [H:0]     sb;
  logic [H-1:0]   core_x;
  logic [H-1:0]   core_y;
  logic [N-1:0]   core_p;
  logic [N+1:0]   mid;
  logic [2*N-1:0] p_next;

  assign sa = {1'b0, a_reg[H-1:0]} + {1'b0, a_reg[N-1:H]};
  assign sb = {1'b0, b_reg[H-1:0]} + {1'b0, b_reg[N-1:H]};

`ifdef KSEQ_ACCEPT_IN_DONE_EN
  assign in_ready = (state_reg == KS_IDLE) | ((state_reg == KS_DONE) & out_ready);
`else
  assign in_ready = (state_reg == KS_IDLE);
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == KS_DONE);
  assign busy      = (state_reg != KS_IDLE);
  assign p         = p_reg;

  // Core operands are selected by state; Z1 (and idle states) feed the half sums.
  always_comb begin
    core_x = sa[H-1:0];
    core_y = sb[H-1:0];
    case (state_reg)
      KS_Z0: begin
        core_x = a_reg[H-1:0];
        core_y = b_reg[H-1:0];
      end
      KS_Z2: begin
        core_x = a_reg[N-1:H];
        core_y = b_reg[N-1:H];
      end
      default: ;
    endcase
  end

  karatsuba_16 #(.W(H)) u_core (
    .x    (core_x),
    .y    (core_y),
    .prod (core_p)
  );

  kseq_mid_fix #(.N(N)) u_mid_fix (
    .la     (sa[H-1:0]),
    .lb     (sb[H-1:0]),
    .ca     (sa[H]),
    .cb     (sb[H]),
    .core_p (core_p),
    .z0     (z0_reg),
    .z2     (z2_reg),
    .mid    (mid)
  );

  // z0 < 2^N, so (z2<<N) + z0 is a plain concatenation.
  assign p_next = {z2_reg, z0_reg} + ((2 * N)'(mid) << H);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      KS_IDLE: if (accept) state_next = KS_Z0;
      KS_Z0:   state_next = KS_Z2;
      KS_Z2:   state_next = KS_Z1;
      KS_Z1:   state_next = KS_DONE;
      KS_DONE: begin
        if (out_ready) begin
          state_next = accept ? KS_Z0 : KS_IDLE;
        end
      end
      default: state_next = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= KS_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      z0_reg    <= '0;
      z2_reg    <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
      end
      if (state_reg == KS_Z0) z0_reg <= core_p;
      if (state_reg == KS_Z2) z2_reg <= core_p;
      if (state_reg == KS_Z1) p_reg  <= p_next;
    end
  end

endmodule

// File: tb/tb_karatsuba_seq32_ctrl.sv
// Scoreboard bench for karatsuba_seq32_ctrl: driver pushes a*b expectations, monitor pops on each handshake.
module tb_karatsuba_seq32_ctrl;

`ifdef KSEQ_ACCEPT_IN_DONE_EN
  localparam int EXP_PERIOD = 4;
`else
  localparam int EXP_PERIOD = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] p;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          txn = 0;
  bit          tput_on = 1'b0;
  logic [63:0] sb_q[$];
  int          tput_q[$];

  karatsuba_seq32_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // out_ready policy: 0 = always ready, 1 = random stalls, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake is matched against the oldest expectation.
  initial forever begin
    logic [63:0] exp_p;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      checks++;
      txn++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%h required=no_result", p);
      end else begin
        exp_p = sb_q.pop_front();
        if (p !== exp_p) begin
          errors++;
          $display("FAIL product txn=%0d actual=%h required=%h", txn, p, exp_p);
        end else begin
          $display("txn %0d p=%h ok", txn, p);
        end
      end
      if (tput_on) tput_q.push_back(cyc);
    end
  end

  task automatic send(input logic [31:0] aa, input logic [31:0] bb,
                      input logic [63:0] exp_p, input bit do_push);
    int n;
    bit ok;
    n = 0;
    ok = 1'b1;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        ok = 1'b0;
        break;
      end
    end
    if (ok && do_push) sb_q.push_back(exp_p);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
    end
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    logic [63:0] p0;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset values
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_p", p, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: carries in both half sums; latency counted with the accept edge as edge 1
    set_mode(0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", 64'(n), 64'd4);
    drain(100);

    // 2: fixed patterns
    send(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
    send(32'd3, 32'd5, 64'd15, 1'b1);
    drain(100);

    // 3: back-pressure in DONE, with an in_valid pulse that must be ignored
    set_mode(2);
    send(32'hDEAD_BEEF, 32'h1234_5678, 64'hDEAD_BEEF * 64'h1234_5678, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    p0 = p;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        a = 32'hAAAA_5555;
        b = 32'h0F0F_F0F0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("stall_p", p, p0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    set_mode(0);
    drain(100);

    // 4: reset while in Z2; the aborted product must never surface
    send(32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", p, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    send(32'd7, 32'd9, 64'd63, 1'b1);
    drain(100);

    // 5: back-to-back throughput
    tput_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, 64'(ra) * 64'(rb), 1'b1);
    end
    drain(200);
    tput_on = 1'b0;
    for (int i = 1; i < tput_q.size(); i++) begin
      chk("throughput_period", 64'(tput_q[i] - tput_q[i-1]), 64'(EXP_PERIOD));
    end

    // 6: random operands with random consumer stalls
    set_mode(1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_0000;
        2: ra = 32'h0000_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb, 64'(ra) * 64'(rb), 1'b1);
    end
    drain(2000);
    set_mode(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
